// File: rtl/modred_pkg.sv
// Shared types and helpers for the shift-subtract modular reducer.
package modred_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter width needed to hold DATA_WIDTH iterations.
  function automatic int cnt_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/modred_if.sv
// Request/response bundle for modred_seq; DUT takes the slave side.
interface modred_if #(
  parameter int DATA_WIDTH = 32
);
  logic                         start;
  logic signed [DATA_WIDTH-1:0] m;
  logic        [DATA_WIDTH-1:0] p;
  logic        [DATA_WIDTH-1:0] m_mod_p;
  logic        [DATA_WIDTH-1:0] m_centered;
  logic                         ready;
  logic                         busy;
  logic                         done;
  logic                         err;

  modport master (
    output start, m, p,
    input  m_mod_p, m_centered, ready, busy, done, err
  );

  modport slave (
    input  start, m, p,
    output m_mod_p, m_centered, ready, busy, done, err
  );
endinterface

// File: rtl/modred_step.sv
// One conditional-subtract step of the restoring reduction: rem = (t >= p) ? t - p : t.
module modred_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   t,
  input  logic [DATA_WIDTH-1:0] p,
  output logic [DATA_WIDTH-1:0] rem
);
  logic                  ge;
  logic [DATA_WIDTH-1:0] diff;

  // t < 2p always holds, so the difference fits in DATA_WIDTH bits.
  assign ge   = (t >= {1'b0, p});
  assign diff = t[DATA_WIDTH-1:0] - p;
  assign rem  = ge ? diff : t[DATA_WIDTH-1:0];
endmodule

// File: rtl/modred_seq.sv
// Sequential signed modular reducer: residue in [0,p) after DATA_WIDTH+1 cycles.
// Optional centred residue output enabled by MODRED_CENTERED_EN.
module modred_seq
  import modred_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = cnt_width(DATA_WIDTH)
) (
  input  logic   clk,
  input  logic   rst,
  modred_if.slave bus
);
  state_t                state, state_n;
  logic                  accept;
  logic                  sign;
  logic [DATA_WIDTH-1:0] mag, p_q, rem, rem_n, canon, res_q;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  err_q;

  assign accept = bus.start && (state == IDLE || state == DONE);

  modred_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .t   ({rem, mag[DATA_WIDTH-1]}),
    .p   (p_q),
    .rem (rem_n)
  );

  // Negative operands fold back as p - |m| mod p, except an exact multiple.
  assign canon = (sign && rem != '0) ? (p_q - rem) : rem;

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        if (accept)             state_n = (bus.p == '0) ? DONE : ITER;
        else if (state == DONE) state_n = IDLE;
      end
      ITER:    if (cnt == CNT_WIDTH'(1)) state_n = FIX;
      FIX:     state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign  <= 1'b0;
      mag   <= '0;
      p_q   <= '0;
      rem   <= '0;
      cnt   <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      sign  <= bus.m[DATA_WIDTH-1];
      mag   <= bus.m[DATA_WIDTH-1] ? $unsigned(-bus.m) : $unsigned(bus.m);
      p_q   <= bus.p;
      rem   <= '0;
      cnt   <= CNT_WIDTH'(DATA_WIDTH);
      res_q <= '0;
      err_q <= (bus.p == '0);
    end else if (state == ITER) begin
      rem <= rem_n;
      mag <= mag << 1;
      cnt <= cnt - CNT_WIDTH'(1);
    end else if (state == FIX) begin
      res_q <= canon;
    end
  end

`ifdef MODRED_CENTERED_EN
  logic [DATA_WIDTH-1:0] cent_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                cent_q <= '0;
    else if (accept)         cent_q <= '0;
    else if (state == FIX)   cent_q <= (canon > (p_q >> 1)) ? (canon - p_q) : canon;
  end

  assign bus.m_centered = cent_q;
`else
  assign bus.m_centered = '0;
`endif

  assign bus.m_mod_p = res_q;
  assign bus.err     = err_q;
  assign bus.ready   = (state == IDLE) || (state == DONE);
  assign bus.busy    = (state == ITER) || (state == FIX);
  assign bus.done    = (state == DONE);
endmodule

// File: tb/tb_modred_seq.sv
// Directed bench for modred_seq with DATA_WIDTH=32 and hand-computed residues.
module tb_modred_seq;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc;

  always #5 clk = ~clk;

  modred_if #(.DATA_WIDTH(DW)) bus ();

  modred_seq #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [31:0] cexp(input logic [31:0] c);
`ifdef MODRED_CENTERED_EN
    return c;
`else
    return (c & 32'h0);
`endif
  endfunction

  // Drive a request mid-cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [31:0] mv, input logic [31:0] pv);
    @(negedge clk);
    bus.start = 1'b1;
    bus.m     = mv;
    bus.p     = pv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges until done is seen; bounded so a hung DUT still reaches the summary.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.done && n < 100);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.m     = '0;
    bus.p     = '0;

    #12;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_done",  32'(bus.done),  32'd0);
    chk("rst_err",   32'(bus.err),   32'd0);
    chk("rst_res",   bus.m_mod_p,    32'd0);
    chk("rst_cent",  bus.m_centered, 32'd0);
    @(negedge clk) rst = 1'b1;

    // 100 mod 7 = 2
    issue(32'd100, 32'd7);
    chk("t1_busy",  32'(bus.busy),  32'd1);
    chk("t1_ready", 32'(bus.ready), 32'd0);
    wait_done(cyc);
    chk("t1_lat",  32'(cyc),        32'd33);
    chk("t1_res",  bus.m_mod_p,     32'd2);
    chk("t1_err",  32'(bus.err),    32'd0);
    chk("t1_cent", bus.m_centered,  cexp(32'd2));
    @(posedge clk); #1;
    chk("t1_done_pulse", 32'(bus.done),  32'd0);
    chk("t1_idle_ready", 32'(bus.ready), 32'd1);
    chk("t1_hold",       bus.m_mod_p,    32'd2);

    // Negative operands
    issue(-32'sd100, 32'd7);
    wait_done(cyc);
    chk("t2_res", bus.m_mod_p, 32'd5);
    issue(-32'sd14, 32'd7);
    wait_done(cyc);
    chk("t2_exact", bus.m_mod_p, 32'd0);

    // Most negative operand: 2^31 mod 12289 = 5476
    issue(32'h8000_0000, 32'd12289);
    wait_done(cyc);
    chk("t3_lat",  32'(cyc),       32'd33);
    chk("t3_res",  bus.m_mod_p,    32'd6813);
    chk("t3_cent", bus.m_centered, cexp(-32'sd5476));

    // Illegal modulus
    issue(32'd5, 32'd0);
    chk("t4_done", 32'(bus.done), 32'd1);
    chk("t4_err",  32'(bus.err),  32'd1);
    chk("t4_res",  bus.m_mod_p,   32'd0);
    issue(32'd5, 32'd9);
    wait_done(cyc);
    chk("t4_res2", bus.m_mod_p,  32'd5);
    chk("t4_err2", 32'(bus.err), 32'd0);

    // Start while busy is ignored
    issue(32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.m     = 32'd1;
    bus.p     = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(cyc);
    chk("t5_lat", 32'(cyc + 10), 32'd33);
    chk("t5_res", bus.m_mod_p,   32'd2);

    // Back-to-back: start during the done cycle
    bus.start = 1'b1;
    bus.m     = -32'sd100;
    bus.p     = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("t5_b2b_busy",  32'(bus.busy), 32'd1);
    chk("t5_b2b_clear", bus.m_mod_p,   32'd0);
    wait_done(cyc);
    chk("t5_b2b_lat", 32'(cyc),    32'd33);
    chk("t5_b2b_res", bus.m_mod_p, 32'd5);

    // Asynchronous reset mid-reduction
    issue(32'd100, 32'd7);
    repeat (15) @(posedge clk);
    #1;
    chk("t6_busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_ready", 32'(bus.ready), 32'd1);
    chk("t6_busy",  32'(bus.busy),  32'd0);
    chk("t6_done",  32'(bus.done),  32'd0);
    chk("t6_res",   bus.m_mod_p,    32'd0);
    @(negedge clk) rst = 1'b1;
    issue(32'h8000_0000, 32'd12289);
    wait_done(cyc);
    chk("t6_lat", 32'(cyc),    32'd33);
    chk("t6_res2", bus.m_mod_p, 32'd6813);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
